// File: rtl/uart_pkg.sv
// Shared UART link definitions: command size, command buffer type and receiver states.
package uart_pkg;
  localparam int CMD_BYTES = 12;

  typedef logic [CMD_BYTES-1:0][7:0] cmd_buf_t;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;
endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop input synchroniser plus start/data/stop bit FSM.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_err,
  output logic       idle,
  output logic       start_det
);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic           rx_meta_q, rx_s_q;
  uart_rx_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     shift_q, shift_d;
  logic           byte_valid_q, byte_valid_d;
  logic           byte_err_q, byte_err_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    byte_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        // Leave mid stop bit so a back-to-back start edge is not missed.
        if (cnt_q == FULL_M1) begin
          cnt_d        = '0;
          state_d      = IDLE;
          byte_valid_d = rx_s_q;
          byte_err_d   = !rx_s_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      byte_err_q   <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      byte_err_q   <= byte_err_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = shift_q;
  assign byte_err   = byte_err_q;
  assign idle       = (state_q == IDLE);
  assign start_det  = (state_q == IDLE) && !rx_s_q;
endmodule

// File: rtl/uart_cmd_rx.sv
// Host command receiver: assembles 12 UART bytes into cmd_buf, with framing-error and idle-timeout resync.
module uart_cmd_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_CLKS = 20 * CLKS_PER_BIT
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rx,
  output logic     cmd_valid,
  output cmd_buf_t cmd_buf,
  output logic     frame_err,
  output logic     busy
);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  logic       byte_valid, byte_err, rx_idle, start_det;
  logic [7:0] byte_data;

  logic [3:0]    count_q, count_d;
  cmd_buf_t      stage_q, stage_d;
  cmd_buf_t      cmd_buf_q, cmd_buf_d;
  logic          commit_q, commit_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          frame_err_q, frame_err_d;
  logic [TW-1:0] tmo_q, tmo_d;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_byte (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_err   (byte_err),
    .idle       (rx_idle),
    .start_det  (start_det)
  );

  always_comb begin
    count_d     = count_q;
    stage_d     = stage_q;
    cmd_buf_d   = cmd_buf_q;
    commit_d    = 1'b0;
    cmd_valid_d = 1'b0;
    frame_err_d = 1'b0;
    tmo_d       = tmo_q;

    if (commit_q) begin
      cmd_buf_d   = stage_q;
      cmd_valid_d = 1'b1;
      count_d     = '0;
    end

    if (byte_valid) begin
      stage_d[count_q] = byte_data;
      tmo_d            = '0;
      // The last byte holds count at 11; the commit cycle returns it to 0.
      if (count_q == 4'(CMD_BYTES - 1)) commit_d = 1'b1;
      else                              count_d  = count_q + 4'd1;
    end else if (byte_err) begin
      count_d     = '0;
      frame_err_d = 1'b1;
      tmo_d       = '0;
    end else if (start_det || !rx_idle) begin
      tmo_d = '0;
    end else if (count_q != '0 && !commit_q) begin
      if (tmo_q == TW'(TIMEOUT_CLKS)) begin
        count_d = '0;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      cmd_buf_q   <= '0;
      commit_q    <= 1'b0;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      tmo_q       <= '0;
    end else begin
      count_q     <= count_d;
      cmd_buf_q   <= cmd_buf_d;
      commit_q    <= commit_d;
      cmd_valid_q <= cmd_valid_d;
      frame_err_q <= frame_err_d;
      tmo_q       <= tmo_d;
    end
    // NOTE: staging storage is not reset; count gates it, so stale bytes never reach cmd_buf.
    stage_q <= stage_d;
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_buf   = cmd_buf_q;
  assign frame_err = frame_err_q;
  assign busy      = (count_q != '0) || !rx_idle;
endmodule

// File: doc/uart_cmd_rx.md
Name: uart_cmd_rx

Overview:
- Receive end of the host command link.
- Deserialises an 8N1 UART stream on `rx` and assembles 12 consecutive bytes into a command buffer.
- Presents the buffer with a one-cycle `cmd_valid` strobe to downstream command decode logic.
- Byte 0 on the wire lands in `cmd_buf[0]`, matching the layout the command generator uses when it drives the transmitter.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); must be >= 4.
- TIMEOUT_CLKS, 20*CLKS_PER_BIT, idle clk cycles after a byte before a partial command is discarded.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input, idle high.
- cmd_valid  out  1  one-cycle strobe; `cmd_buf` holds a complete new command.
- cmd_buf  out  [11:0][7:0]  assembled command; byte 0 = first byte received.
- frame_err  out  1  one-cycle strobe on a stop-bit error.
- busy  out  1  high while a partial command (1..11 bytes) is buffered or a byte is in flight.

Behaviour:
- Reset:
  - `cmd_valid`, `frame_err` and `busy` = 0; `cmd_buf` = all zeros.
  - Byte count = 0; bit FSM = IDLE; synchroniser flops = 1.
  - Reset at any point, including mid-byte or mid-command, discards all partial state.
- Input sync: `rx` passes through a 2-flop synchroniser (`rx_s`). All decisions use `rx_s`.
- Bit FSM (in sub-module):
  - IDLE: stays while `rx_s`=1. On `rx_s`=0, load counter and go to START.
  - START: wait CLKS_PER_BIT/2 cycles, then sample `rx_s`.
    - 0 -> DATA, bit index = 0.
    - 1 -> false start, back to IDLE; no strobe.
  - DATA: every CLKS_PER_BIT cycles, sample one bit into the shift register, LSB first. After bit 7 go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample `rx_s`.
    - 1 -> pulse `byte_valid` for 1 cycle with `byte_data`.
    - 0 -> pulse `byte_err` for 1 cycle.
    - Either way return to IDLE immediately (mid stop bit), so a back-to-back start bit is caught.
- Assembler:
  - On `byte_valid`, write `byte_data` into a staging buffer at index `count`, then `count`++.
  - Commit: when the byte at `count`=11 is written, on the next cycle:
    - copy staging to `cmd_buf` (all 12 bytes update in the same cycle);
    - pulse `cmd_valid`;
    - set `count` = 0.
  - `cmd_buf` is otherwise stable; partial commands never disturb it.
  - Latency: `cmd_valid` rises 2 clk cycles after the stop-bit sample of byte 11.
- Framing error: `byte_err` sets `count`=0, drops the partial command and pulses `frame_err` in the next cycle. `cmd_valid` is not asserted.
- Timeout:
  - The idle counter starts at each `byte_valid` while `count` is in 1..11, and clears when the bit FSM leaves IDLE.
  - When it reaches TIMEOUT_CLKS, `count` = 0 silently (resync).
  - The counter saturates and does not run when `count`=0.
- Simultaneous events: a timeout and a start bit in the same cycle -> start wins (counter cleared, `count` kept).
- `busy` = (`count` != 0) OR (bit FSM != IDLE).
- Width rules: `count` is 4 bits and never exceeds 11. The bit counter is sized `$clog2(CLKS_PER_BIT)+1`.

Decomposition:
- Package `uart_pkg`:
  - `CMD_BYTES` = 12;
  - `typedef logic [CMD_BYTES-1:0][7:0] cmd_buf_t`;
  - `typedef enum {IDLE, START, DATA, STOP} uart_rx_state_t`.
  - The same package is shared with the transmitter and the command generator.
- Sub-module `uart_rx_byte`:
  - Contains the synchroniser and bit FSM.
  - Outputs `byte_valid`, `byte_data[7:0]`, `byte_err`.
  - The top level holds the assembler and timeout only.

Test Plan (CLKS_PER_BIT=8, TIMEOUT_CLKS=160):
- Send 14 00 00 01 98 00 00 00 00 00 00 00 back-to-back -> exactly one `cmd_valid` pulse, 2 cycles after the last stop sample. `cmd_buf[0]`=8'h14, `[3]`=8'h01, `[4]`=8'h98, all others 8'h00. `busy` returns to 0.
- Two consecutive 12-byte frames (AA.. then 55..) with zero idle between stop and start -> two `cmd_valid` pulses; `cmd_buf` = all 8'hAA, then all 8'h55. No `frame_err`.
- Byte 3 sent with stop bit = 0, then 12 good bytes -> one `frame_err` pulse, `count` reset. Exactly one `cmd_valid`, carrying the 12 good bytes. `cmd_buf` unchanged before that pulse.
- Send 5 bytes, hold `rx` high for 200 cycles, then send 12 bytes 01..0C -> single `cmd_valid`, `cmd_buf[0]`=8'h01, `cmd_buf[11]`=8'h0C.
- Drive `rx` low for 2 cycles only -> false start rejected: no `byte_valid`, `busy` drops back to 0 within CLKS_PER_BIT/2+3 cycles.
- Assert `rst` for 1 cycle mid-bit of byte 7, then send 12 bytes -> all outputs 0 the cycle after `rst`. One `cmd_valid` with the new 12 bytes only.
